// File: rtl/cpu_sequencer.sv
// cpu_sequencer
// Four-state instruction sequencer wrapped around an external combinational
// ALU. An accepted instruction is latched, its operands are read from a
// four-entry register file, the ALU result is captured, and the result is
// written back to the destination register while the flags are updated.
//
// Parameters:
//   WB_ON_DIV0  1: a divide-by-zero still writes the ALU result to rd
//               0: a divide-by-zero leaves rd (and flag_z) untouched
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   instr_valid/ready   instruction handshake (ready only while idle)
//   instr[15:0]         [15] imm, [14:12] opcode, [11:10] rd, [9:8] rs,
//                       [7:6] rt, [7:0] imm8
//   alu_a, alu_b        ALU operands, held from DECODE until back in IDLE
//   alu_sel             ALU operation (the opcode)
//   alu_out, alu_carry  ALU result and carry (carry set on divide-by-zero)
//   dbg_addr, dbg_data  combinational register-file debug read port
//   done                one-cycle pulse when an instruction retires
//   flag_c, flag_z      carry / zero flags of the last retired instruction
//   div0_err            sticky divide-by-zero indicator
module cpu_sequencer #(
    parameter bit WB_ON_DIV0 = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_sel,
    input  logic [7:0]  alu_out,
    input  logic        alu_carry,
    input  logic [1:0]  dbg_addr,
    output logic [7:0]  dbg_data,
    output logic        done,
    output logic        flag_c,
    output logic        flag_z,
    output logic        div0_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DECODE    = 2'd1,
        EXECUTE   = 2'd2,
        WRITEBACK = 2'd3
    } state_t;

    localparam logic [2:0] OP_DIV = 3'b110;

    state_t      state;
    state_t      state_next;
    logic [15:0] instr_q;
    logic [7:0]  regs [4];
    logic [7:0]  result_q;
    logic        carry_q;
    logic        div0_q;

    logic        imm_flag;
    logic [2:0]  opcode;
    logic [1:0]  rd;
    logic [1:0]  rs;
    logic [1:0]  rt;
    logic [7:0]  imm8;
    logic        wb_enable;

    // Fields always come from the captured copy, so the instr bus is free
    // to change as soon as the instruction has been accepted.
    assign imm_flag = instr_q[15];
    assign opcode   = instr_q[14:12];
    assign rd       = instr_q[11:10];
    assign rs       = instr_q[9:8];
    assign rt       = instr_q[7:6];
    assign imm8     = instr_q[7:0];

    assign instr_ready = (state == IDLE);
    assign dbg_data    = regs[dbg_addr];

    // A divide-by-zero only commits its result when the build allows it.
    assign wb_enable = !div0_q || WB_ON_DIV0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (instr_valid) state_next = DECODE;
            DECODE:    state_next = EXECUTE;
            EXECUTE:   state_next = WRITEBACK;
            WRITEBACK: state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Datapath. done is registered on the writeback edge, so it rises in the
    // same cycle the new register value and flags become visible, three
    // edges after acceptance. Reset clears everything, aborting any
    // instruction in flight before it can write back or pulse done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q  <= 16'h0000;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= 8'h00;
            end
            alu_a    <= 8'h00;
            alu_b    <= 8'h00;
            alu_sel  <= 3'b000;
            result_q <= 8'h00;
            carry_q  <= 1'b0;
            div0_q   <= 1'b0;
            done     <= 1'b0;
            flag_c   <= 1'b0;
            flag_z   <= 1'b0;
            div0_err <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                    end
                end
                DECODE: begin
                    alu_a   <= regs[rs];
                    alu_b   <= imm_flag ? imm8 : regs[rt];
                    alu_sel <= opcode;
                end
                EXECUTE: begin
                    result_q <= alu_out;
                    carry_q  <= alu_carry;
                    div0_q   <= (alu_sel == OP_DIV) && (alu_b == 8'h00);
                end
                WRITEBACK: begin
                    if (wb_enable) begin
                        regs[rd] <= result_q;
                        flag_z   <= (result_q == 8'h00);
                    end
                    flag_c <= carry_q || div0_q;
                    if (div0_q) begin
                        div0_err <= 1'b1;
                    end
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer
// Runs two sequencers side by side on the same instruction stream, one
// built with WB_ON_DIV0 = 1 (index 1) and one with WB_ON_DIV0 = 0 (index 0).
// Each has its own behavioural ALU. A reference model holds the expected
// register file and flags per instance and is updated instruction by
// instruction from the architectural rules.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic [1:0]  dbg_addr = 2'd0;

    logic        ready_s     [2];
    logic [7:0]  alu_a_s     [2];
    logic [7:0]  alu_b_s     [2];
    logic [2:0]  alu_sel_s   [2];
    logic [7:0]  alu_out_s   [2];
    logic        alu_carry_s [2];
    logic [7:0]  dbg_data_s  [2];
    logic        done_s      [2];
    logic        flag_c_s    [2];
    logic        flag_z_s    [2];
    logic        div0_err_s  [2];

    // Reference state, index = WB_ON_DIV0 setting of the instance
    logic [7:0]  m_reg [2][4];
    logic        m_c   [2];
    logic        m_z   [2];
    logic        m_e   [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_sequencer #(.WB_ON_DIV0(1'b1)) dut_w1 (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(ready_s[1]), .instr(instr),
        .alu_a(alu_a_s[1]), .alu_b(alu_b_s[1]), .alu_sel(alu_sel_s[1]),
        .alu_out(alu_out_s[1]), .alu_carry(alu_carry_s[1]),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data_s[1]),
        .done(done_s[1]), .flag_c(flag_c_s[1]), .flag_z(flag_z_s[1]),
        .div0_err(div0_err_s[1])
    );

    cpu_sequencer #(.WB_ON_DIV0(1'b0)) dut_w0 (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(ready_s[0]), .instr(instr),
        .alu_a(alu_a_s[0]), .alu_b(alu_b_s[0]), .alu_sel(alu_sel_s[0]),
        .alu_out(alu_out_s[0]), .alu_carry(alu_carry_s[0]),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data_s[0]),
        .done(done_s[0]), .flag_c(flag_c_s[0]), .flag_z(flag_z_s[0]),
        .div0_err(div0_err_s[0])
    );

    // Behavioural ALU: returns {carry, result}
    function automatic logic [8:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {(a < b), 8'(a - b)};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {1'b0, b};
            3'd6:    return (b == 8'h00) ? 9'h100 : {1'b0, 8'(a / b)};
            default: return {8'h00, (a == b)};
        endcase
    endfunction

    assign {alu_carry_s[0], alu_out_s[0]} = alu_fn(alu_sel_s[0], alu_a_s[0], alu_b_s[0]);
    assign {alu_carry_s[1], alu_out_s[1]} = alu_fn(alu_sel_s[1], alu_a_s[1], alu_b_s[1]);

    function automatic logic [15:0] mk(input logic imm, input logic [2:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs, input logic [1:0] rt, input logic [7:0] imm8);
        return imm ? {1'b1, op, rd, rs, imm8} : {1'b0, op, rd, rs, rt, 6'b000000};
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 4; r++) m_reg[k][r] = 8'h00;
            m_c[k] = 1'b0;
            m_z[k] = 1'b0;
            m_e[k] = 1'b0;
        end
    endtask

    // Architectural effect of one instruction on both reference instances
    task automatic modelExec(input logic [15:0] ins);
        logic [7:0] a, b;
        logic [8:0] res;
        logic       div0;
        for (int k = 0; k < 2; k++) begin
            a    = m_reg[k][ins[9:8]];
            b    = ins[15] ? ins[7:0] : m_reg[k][ins[7:6]];
            res  = alu_fn(ins[14:12], a, b);
            div0 = (ins[14:12] == 3'd6) && (b == 8'h00);
            if (!div0 || k == 1) begin
                m_reg[k][ins[11:10]] = res[7:0];
                m_z[k] = (res[7:0] == 8'h00);
            end
            m_c[k] = res[8] || div0;
            if (div0) m_e[k] = 1'b1;
        end
    endtask

    // Issues one instruction and follows it cycle by cycle to retirement
    task automatic applyStimulus(input string name, input logic [15:0] ins);
        logic [7:0] exp_a [2];
        logic [7:0] exp_b [2];
        logic [7:0] old_v [2];
        @(negedge clk);
        for (int k = 0; k < 2; k++)
            checkOutput($sformatf("%s ready_idle_w%0d", name, k), 8'(ready_s[k]), 8'd1);
        instr       = ins;
        instr_valid = 1'b1;
        dbg_addr    = ins[11:10];
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr       = 16'($urandom);
        for (int k = 0; k < 2; k++) begin
            exp_a[k] = m_reg[k][ins[9:8]];
            exp_b[k] = ins[15] ? ins[7:0] : m_reg[k][ins[7:6]];
            old_v[k] = m_reg[k][ins[11:10]];
            checkOutput($sformatf("%s ready_decode_w%0d", name, k), 8'(ready_s[k]), 8'd0);
            checkOutput($sformatf("%s done_decode_w%0d", name, k), 8'(done_s[k]), 8'd0);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("%s ready_exec_w%0d", name, k), 8'(ready_s[k]), 8'd0);
            checkOutput($sformatf("%s alu_a_w%0d", name, k), alu_a_s[k], exp_a[k]);
            checkOutput($sformatf("%s alu_b_w%0d", name, k), alu_b_s[k], exp_b[k]);
            checkOutput($sformatf("%s alu_sel_w%0d", name, k), 8'(alu_sel_s[k]), 8'(ins[14:12]));
        end
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("%s ready_wb_w%0d", name, k), 8'(ready_s[k]), 8'd0);
            checkOutput($sformatf("%s done_wb_w%0d", name, k), 8'(done_s[k]), 8'd0);
            checkOutput($sformatf("%s dbg_old_w%0d", name, k), dbg_data_s[k], old_v[k]);
        end
        modelExec(ins);
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("%s done_w%0d", name, k), 8'(done_s[k]), 8'd1);
            checkOutput($sformatf("%s ready_after_w%0d", name, k), 8'(ready_s[k]), 8'd1);
            checkOutput($sformatf("%s dbg_new_w%0d", name, k), dbg_data_s[k], m_reg[k][ins[11:10]]);
            checkOutput($sformatf("%s flag_c_w%0d", name, k), 8'(flag_c_s[k]), 8'(m_c[k]));
            checkOutput($sformatf("%s flag_z_w%0d", name, k), 8'(flag_z_s[k]), 8'(m_z[k]));
            checkOutput($sformatf("%s div0_err_w%0d", name, k), 8'(div0_err_s[k]), 8'(m_e[k]));
        end
    endtask

    // Reads every register through the debug port while idle
    task automatic checkRegs(input string name);
        for (int r = 0; r < 4; r++) begin
            dbg_addr = 2'(r);
            #1;
            for (int k = 0; k < 2; k++)
                checkOutput($sformatf("%s R%0d_w%0d", name, r, k), dbg_data_s[k], m_reg[k][r]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] tp [12];
        int          done_seen;

        // Reset values
        modelReset();
        #12;
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("rst ready_w%0d", k), 8'(ready_s[k]), 8'd1);
            checkOutput($sformatf("rst done_w%0d", k), 8'(done_s[k]), 8'd0);
            checkOutput($sformatf("rst alu_a_w%0d", k), alu_a_s[k], 8'h00);
            checkOutput($sformatf("rst alu_b_w%0d", k), alu_b_s[k], 8'h00);
            checkOutput($sformatf("rst alu_sel_w%0d", k), 8'(alu_sel_s[k]), 8'd0);
            checkOutput($sformatf("rst flags_w%0d", k), 8'({flag_c_s[k], flag_z_s[k], div0_err_s[k]}), 8'd0);
        end
        checkRegs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Add with wrap to zero
        applyStimulus("addi_r1", mk(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h05));
        applyStimulus("addi_r2", mk(1'b1, 3'd0, 2'd2, 2'd0, 2'd0, 8'hFB));
        applyStimulus("add_r3", mk(1'b0, 3'd0, 2'd3, 2'd1, 2'd2, 8'h00));
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("add_r3 const_val_w%0d", k), dbg_data_s[k], 8'h00);
            checkOutput($sformatf("add_r3 const_c_w%0d", k), 8'(flag_c_s[k]), 8'd1);
            checkOutput($sformatf("add_r3 const_z_w%0d", k), 8'(flag_z_s[k]), 8'd1);
        end

        // Divide by zero, then one where suppressed writeback is visible
        applyStimulus("div_r0", mk(1'b0, 3'd6, 2'd0, 2'd1, 2'd0, 8'h00));
        for (int k = 0; k < 2; k++)
            checkOutput($sformatf("div_r0 const_err_w%0d", k), 8'(div0_err_s[k]), 8'd1);
        applyStimulus("addi_r3", mk(1'b1, 3'd0, 2'd3, 2'd1, 2'd0, 8'h10));
        applyStimulus("div_r1", mk(1'b0, 3'd6, 2'd1, 2'd1, 2'd0, 8'h00));
        checkOutput("div_r1 const_r1_w1", dbg_data_s[1], 8'h00);
        checkOutput("div_r1 const_r1_w0", dbg_data_s[0], 8'h05);
        checkOutput("div_r1 const_z_w1", 8'(flag_z_s[1]), 8'd1);
        checkOutput("div_r1 const_z_w0", 8'(flag_z_s[0]), 8'd0);
        checkOutput("div_r1 const_c_w0", 8'(flag_c_s[0]), 8'd1);

        // Compare of equal values
        applyStimulus("ld_r1_3c", mk(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h3C));
        applyStimulus("ld_r2_3c", mk(1'b1, 3'd0, 2'd2, 2'd0, 2'd0, 8'h3C));
        applyStimulus("cmp_r3", mk(1'b0, 3'd7, 2'd3, 2'd1, 2'd2, 8'h00));
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("cmp_r3 const_val_w%0d", k), dbg_data_s[k], 8'h01);
            checkOutput($sformatf("cmp_r3 const_z_w%0d", k), 8'(flag_z_s[k]), 8'd0);
        end

        // Subtract with borrow, destination equals source
        applyStimulus("ld_r1_03", mk(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h03));
        applyStimulus("ld_r2_05", mk(1'b1, 3'd0, 2'd2, 2'd0, 2'd0, 8'h05));
        applyStimulus("sub_r1", mk(1'b0, 3'd1, 2'd1, 2'd1, 2'd2, 8'h00));
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("sub_r1 const_val_w%0d", k), dbg_data_s[k], 8'hFE);
            checkOutput($sformatf("sub_r1 const_c_w%0d", k), 8'(flag_c_s[k]), 8'd1);
        end

        // Random instruction stream
        for (int n = 0; n < 30; n++)
            applyStimulus($sformatf("rnd%0d", n), 16'($urandom));
        checkRegs("rnd");

        // Back-to-back offers with instr_valid held high
        for (int k = 0; k < 12; k++) tp[k] = 16'($urandom);
        done_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            instr       = tp[k];
            instr_valid = 1'b1;
            for (int j = 0; j < 2; j++)
                checkOutput($sformatf("tp ready_c%0d_w%0d", k, j), 8'(ready_s[j]), 8'((k % 4) == 0));
            if ((k % 4) == 0) modelExec(tp[k]);
            @(posedge clk); #1;
            if (done_s[1]) done_seen++;
        end
        @(negedge clk);
        instr_valid = 1'b0;
        checkOutput("tp done_count", 8'(done_seen), 8'd3);
        checkRegs("tp");
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("tp flag_c_w%0d", k), 8'(flag_c_s[k]), 8'(m_c[k]));
            checkOutput($sformatf("tp flag_z_w%0d", k), 8'(flag_z_s[k]), 8'(m_z[k]));
        end

        // Reset asserted mid-EXECUTE
        @(negedge clk);
        instr       = mk(1'b1, 3'd0, 2'd2, 2'd0, 2'd0, 8'h77);
        instr_valid = 1'b1;
        dbg_addr    = 2'd2;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("abort ready_w%0d", k), 8'(ready_s[k]), 8'd1);
            checkOutput($sformatf("abort alu_a_w%0d", k), alu_a_s[k], 8'h00);
            checkOutput($sformatf("abort alu_b_w%0d", k), alu_b_s[k], 8'h00);
            checkOutput($sformatf("abort alu_sel_w%0d", k), 8'(alu_sel_s[k]), 8'd0);
            checkOutput($sformatf("abort done_w%0d", k), 8'(done_s[k]), 8'd0);
            checkOutput($sformatf("abort flags_w%0d", k), 8'({flag_c_s[k], flag_z_s[k], div0_err_s[k]}), 8'd0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++)
                checkOutput($sformatf("abort no_done_c%0d_w%0d", c, k), 8'(done_s[k]), 8'd0);
        end
        checkRegs("abort");
        applyStimulus("post_rst", mk(1'b1, 3'd0, 2'd3, 2'd0, 2'd0, 8'h42));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter WB_ON_DIV0, default 1: 1 = write ALU result (0x00) to rd on divide-by-zero; 0 = suppress that writeback.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 instr_valid  in  1  instruction offered.
REQ-005 instr_ready  out  1  sequencer can accept an instruction.
REQ-006 instr  in  16  [15] imm flag, [14:12] opcode, [11:10] rd, [9:8] rs, [7:6] rt, [7:0] imm8.
REQ-007 alu_a  out  8  ALU operand A.
REQ-008 alu_b  out  8  ALU operand B.
REQ-009 alu_sel  out  3  ALU operation select, equal to the opcode.
REQ-010 alu_out  in  8  ALU result.
REQ-011 alu_carry  in  1  ALU carry/overflow; set for divide-by-zero.
REQ-012 dbg_addr  in  2  register-file debug read address.
REQ-013 dbg_data  out  8  R[dbg_addr], combinational.
REQ-014 done  out  1  one-cycle pulse, instruction retired.
REQ-015 flag_c  out  1  carry flag of last retired instruction.
REQ-016 flag_z  out  1  zero flag, set when last written result == 0x00.
REQ-017 div0_err  out  1  sticky, divide-by-zero seen.

Function
REQ-018 Register file: four 8-bit registers R0..R3; all are writable and none reads as constant.
REQ-019 FSM states: IDLE, DECODE, EXECUTE, WRITEBACK.
REQ-020 FSM transitions: IDLE->DECODE on instr_valid&&instr_ready; DECODE->EXECUTE; EXECUTE->WRITEBACK; WRITEBACK->IDLE, unconditional.
REQ-021 instr_ready = 1 only in IDLE; the instruction is captured into an internal register on acceptance, and later changes on instr do not affect it.
REQ-022 DECODE: alu_a <= R[rs]; alu_b <= imm8 when imm flag = 1, else R[rt]; alu_sel <= opcode.
REQ-023 alu_a, alu_b and alu_sel hold stable from DECODE until return to IDLE; the ALU is combinational and is sampled at the end of EXECUTE.
REQ-024 EXECUTE: latch alu_out and alu_carry into internal result registers.
REQ-025 WRITEBACK: R[rd] <= result; flag_c <= carry; flag_z <= (result == 0); done = 1 for this cycle only.
REQ-026 Divide-by-zero (opcode 110 with operand B = 0): div0_err <= 1; flag_c <= 1.
REQ-027 Divide-by-zero writeback: R[rd] is written only if WB_ON_DIV0 = 1; flag_z is updated only when the write occurs.
REQ-028 Compare (opcode 111) writes 0x01 or 0x00 to rd, as any other operation.
REQ-029 rd may equal rs or rt; operands are read in DECODE, so the old value is used.
REQ-030 Latency: acceptance edge to done = 3 cycles; maximum throughput is one instruction per 4 cycles.
REQ-031 A dbg_addr read of a register being written in the same WRITEBACK cycle returns the old value; the new value is visible from the next cycle.
REQ-032 Arithmetic is modulo 256; the carry is whatever the ALU reports, and the sequencer does no width extension.

Reset
REQ-033 rst_n = 0 forces, immediately: state IDLE; R0..R3 = 0x00; alu_a, alu_b, alu_sel = 0; done, flag_c, flag_z, div0_err = 0.
REQ-034 instr_ready = 1 while in IDLE after reset.
REQ-035 Reset in any state aborts the in-flight instruction: no writeback, no done pulse.
REQ-036 div0_err clears only on reset.

Verification
REQ-037 Reset, then ADDI R1 = R0 + 0x05; ADDI R2 = R0 + 0xFB; ADD R3 = R1 + R2 -> R3 = 0x00, flag_c = 1, flag_z = 1, done pulse 3 cycles after each acceptance.
REQ-038 DIV R0 = R1 / R0 with R1 = 0x05 and R0 = 0 -> div0_err = 1, flag_c = 1, R0 = 0x00 (WB_ON_DIV0 = 1); repeat with WB_ON_DIV0 = 0 -> R0 unchanged.
REQ-039 Hold instr_valid = 1 continuously with changing instr -> exactly one acceptance per 4 cycles; instr_ready low in DECODE, EXECUTE and WRITEBACK.
REQ-040 Assert rst_n = 0 during EXECUTE -> all outputs at reset values with no clock edge; no done pulse; the target register stays 0x00.
REQ-041 CMP with R1 = R2 = 0x3C -> rd = 0x01, flag_z = 0; dbg_data shows the old value in WRITEBACK and the new value on the next cycle.
REQ-042 SUB R1 = R1 - R2 (0x03 - 0x05) -> R1 = 0xFE, flag_c = 1, and the old R1 is used as the operand.
